// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master: one byte out on MOSI / one byte in from MISO per accepted command.
// Optional build macro SPI_LOOPBACK_EN feeds the internal MOSI register back into the RX shifter.
module spi_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_enable,
  input  logic [31:0] wdata,
  output logic [31:0] spi_data,
  output logic        spi_ack,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n
);

  typedef enum logic {
    ST_IDLE,
    ST_XFER
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_div;
  logic [2:0] r_bit;
  logic       r_sclk;
  logic       r_mosi;
  logic       r_cs_n;
  logic       r_ack;
  logic       r_overrun;
  logic       r_keep;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic [7:0] r_rx_byte;

  logic       w_accept;
  logic       w_wrap;
  logic       w_rise;
  logic       w_fall;
  logic       w_done;
  logic       w_rx_in;
  logic       w_unused;

`ifdef SPI_LOOPBACK_EN
  assign w_rx_in  = r_mosi;
  assign w_unused = &{1'b0, wdata[31:9], spi_miso};
`else
  assign w_rx_in  = spi_miso;
  assign w_unused = &{1'b0, wdata[31:9]};
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_wrap       = 1'b0;
    w_rise       = 1'b0;
    w_fall       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (spi_enable) begin
          w_accept     = 1'b1;
          w_state_next = ST_XFER;
        end
      end
      ST_XFER: begin
        w_wrap = (r_div == DIV_LAST);
        w_rise = w_wrap && !r_sclk;
        w_fall = w_wrap && r_sclk;
        w_done = w_fall && (r_bit == 3'd7);
        if (w_done) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div     <= 8'd0;
      r_bit     <= 3'd0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_ack     <= 1'b0;
      r_overrun <= 1'b0;
      r_keep    <= 1'b0;
      r_tx      <= 8'd0;
      r_rx      <= 8'd0;
      r_rx_byte <= 8'd0;
    end else if (w_accept) begin
      r_tx      <= wdata[7:0];
      r_keep    <= wdata[8];
      r_ack     <= 1'b0;
      r_overrun <= 1'b0;
      r_cs_n    <= 1'b0;
      r_mosi    <= wdata[7];
      r_div     <= 8'd0;
      r_bit     <= 3'd0;
      r_sclk    <= 1'b0;
    end else if (r_state == ST_XFER) begin
      // A strobe while busy, including on the completion edge, is dropped and flagged.
      if (spi_enable) r_overrun <= 1'b1;
      r_div <= w_wrap ? 8'd0 : r_div + 8'd1;
      if (w_wrap) r_sclk <= ~r_sclk;
      if (w_rise) r_rx <= {r_rx[6:0], w_rx_in};
      if (w_done) begin
        r_rx_byte <= r_rx;
        r_ack     <= 1'b1;
        r_cs_n    <= !r_keep;
        r_mosi    <= 1'b0;
        r_bit     <= 3'd0;
      end else if (w_fall) begin
        r_bit  <= r_bit + 3'd1;
        r_tx   <= {r_tx[6:0], 1'b0};
        r_mosi <= r_tx[6];
      end
    end
  end

  assign spi_data = {23'd0, r_overrun, r_rx_byte};
  assign spi_ack  = r_ack;
  assign spi_sclk = r_sclk;
  assign spi_mosi = r_mosi;
  assign spi_cs_n = r_cs_n;

endmodule
